// File: rtl/fht_addr_gen_pkg.sv
// Shared FSM encoding, defaults and width helper for the FHT address generator.
package fht_addr_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fht_state_e;

    localparam int FHT_A_BIT_DEFAULT = 8;
    localparam int FHT_LAT_DEFAULT   = 3;

    function automatic int fht_stage_w(input int a_bit);
        return (a_bit > 2) ? $clog2(a_bit) : 1;
    endfunction

endpackage

// File: rtl/fht_addr_gen_if.sv
// Control/address bus between the FHT sequencer and its RAM/ROM/butterfly datapath.
interface fht_addr_gen_if
    import fht_addr_gen_pkg::*;
#(
    parameter int A_BIT = FHT_A_BIT_DEFAULT
) ();

    localparam int SW = fht_stage_w(A_BIT);

    logic             iSTART;
    logic             oBUSY;
    logic             oRD_VALID;
    logic [A_BIT-1:0] oRD_ADDR_0;
    logic [A_BIT-1:0] oRD_ADDR_1;
    logic [A_BIT-1:0] oRD_ADDR_2;
    logic [A_BIT-2:0] oROM_ADDR;
    logic             oWE;
    logic [A_BIT-1:0] oWR_ADDR_0;
    logic [A_BIT-1:0] oWR_ADDR_1;
    logic             oBANK;
    logic [SW-1:0]    oSTAGE;
    logic             oDONE;

    modport master (
        output iSTART,
        input  oBUSY, oRD_VALID, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR,
        input  oWE, oWR_ADDR_0, oWR_ADDR_1, oBANK, oSTAGE, oDONE
    );

    modport slave (
        input  iSTART,
        output oBUSY, oRD_VALID, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR,
        output oWE, oWR_ADDR_0, oWR_ADDR_1, oBANK, oSTAGE, oDONE
    );

endinterface

// File: rtl/fht_addr_gen_delay_line.sv
// Reset-clearable shift register; carries read strobes/addresses forward to the write port.
module fht_delay_line
    import fht_addr_gen_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = FHT_LAT_DEFAULT
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = iD;
        for (int n = 1; n < DEPTH; n++) pipe_d[n] = pipe_q[n-1];
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) pipe_q <= '0;
        else         pipe_q <= pipe_d;
    end

    assign oQ = pipe_q[DEPTH-1];

endmodule

// File: rtl/fht_addr_gen.sv
// In-place radix-2 FHT sequencer: per-stage butterfly read/ROM addresses plus
// latency-matched write addresses, ping-ponging between two RAM banks.
module fht_addr_gen
    import fht_addr_gen_pkg::*;
#(
    parameter int A_BIT = FHT_A_BIT_DEFAULT,
    parameter int LAT   = FHT_LAT_DEFAULT
) (
    input  logic          iCLK,
    input  logic          iRESET,
    fht_addr_gen_if.slave bus
);

    localparam int IW = A_BIT - 1;
    localparam int SW = fht_stage_w(A_BIT);
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int WW = 2 * A_BIT + 1;

    // N/2-1 is all ones in IW bits
    localparam logic [IW-1:0] I_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(A_BIT - 1);
    localparam logic [DW-1:0] D_LAST = DW'(LAT - 1);

    fht_state_e       state_q, state_d;
    logic [IW-1:0]    i_q, i_d;
    logic [SW-1:0]    s_q, s_d;
    logic [DW-1:0]    d_q, d_d;
    logic             bank_q, bank_d;
    logic             rd_valid_q, rd_valid_d;
    logic [A_BIT-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic [IW-1:0]    rom_q, rom_d;
    logic [A_BIT-1:0] h, k, b, kr;
    logic             busy, done;
    logic [WW-1:0]    wr_q;

    // state register
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.iSTART) state_d = ST_RUN;
            ST_RUN:   if (i_q == I_LAST) state_d = ST_DRAIN;
            ST_DRAIN: if (d_q == D_LAST) state_d = (s_q == S_LAST) ? ST_DONE : ST_RUN;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        i_d    = i_q;
        s_d    = s_q;
        d_d    = d_q;
        bank_d = bank_q;
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_RUN) begin
                    i_d    = '0;
                    s_d    = '0;
                    bank_d = 1'b0;
                end
            end
            ST_RUN: begin
                i_d = i_q + 1'b1;
                if (state_d == ST_DRAIN) d_d = '0;
            end
            ST_DRAIN: begin
                d_d = d_q + 1'b1;
                if (state_d == ST_RUN) begin
                    i_d    = '0;
                    s_d    = s_q + 1'b1;
                    bank_d = ~bank_q;
                end
            end
            default: ;
        endcase
    end

    // Addresses are computed from next-cycle counters so the registered
    // outputs line up with rd_valid_q.
    always_comb begin
        h  = A_BIT'(1) << s_d;
        k  = A_BIT'(i_d) & (h - 1'b1);
        b  = (A_BIT'(i_d) & ~(h - 1'b1)) << 1;
        kr = (h - k) & (h - 1'b1);
        rd_valid_d = (state_d == ST_RUN);
        x0_d  = '0;
        x1_d  = '0;
        x2_d  = '0;
        rom_d = '0;
        if (rd_valid_d) begin
            x0_d  = b + k;
            x1_d  = b + h + k;
            x2_d  = b + h + kr;
            rom_d = IW'(k << (IW - int'(s_d)));
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            i_q        <= '0;
            s_q        <= '0;
            d_q        <= '0;
            bank_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            x0_q       <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            rom_q      <= '0;
        end else begin
            i_q        <= i_d;
            s_q        <= s_d;
            d_q        <= d_d;
            bank_q     <= bank_d;
            rd_valid_q <= rd_valid_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            rom_q      <= rom_d;
        end
    end

    fht_delay_line #(.WIDTH(WW), .DEPTH(LAT)) u_wr_dly (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iD     ({rd_valid_q, x0_q, x1_q}),
        .oQ     (wr_q)
    );

    assign bus.oBUSY      = busy;
    assign bus.oDONE      = done;
    assign bus.oRD_VALID  = rd_valid_q;
    assign bus.oRD_ADDR_0 = x0_q;
    assign bus.oRD_ADDR_1 = x1_q;
    assign bus.oRD_ADDR_2 = x2_q;
    assign bus.oROM_ADDR  = rom_q;
    assign bus.oBANK      = bank_q;
    assign bus.oSTAGE     = s_q;
    assign bus.oWE        = wr_q[WW-1];
    assign bus.oWR_ADDR_0 = wr_q[2*A_BIT-1:A_BIT];
    assign bus.oWR_ADDR_1 = wr_q[A_BIT-1:0];

endmodule

// File: tb/tb_fht_addr_gen.sv
// Bench for fht_addr_gen: A_BIT=3 and A_BIT=8 instances checked cycle by cycle
// against an arithmetic model of the butterfly schedule.
module tb_fht_addr_gen;

    localparam int LAT = 3;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cap1[$];
    int   cap2[$];

    fht_addr_gen_if #(.A_BIT(3)) if3 ();
    fht_addr_gen_if #(.A_BIT(8)) if8 ();

    fht_addr_gen #(.A_BIT(3), .LAT(LAT)) dut3 (.iCLK(clk), .iRESET(rst_n), .bus(if3));
    fht_addr_gen #(.A_BIT(8), .LAT(LAT)) dut8 (.iCLK(clk), .iRESET(rst_n), .bus(if8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Schedule model: cycle c (1 = first busy cycle) of a transform of length 2^ab.
    function automatic void model(input int ab, input int c, output bit v,
                                  output int x0, output int x1, output int x2,
                                  output int rom, output int s);
        int half, per, off, h, k, b;
        half = (1 << ab) / 2;
        per  = half + LAT;
        v = 0; x0 = 0; x1 = 0; x2 = 0; rom = 0; s = 0;
        if (c >= 1) begin
            s = (c - 1) / per;
            if (s < ab) begin
                off = (c - 1) % per;
                if (off < half) begin
                    v   = 1;
                    h   = 1 << s;
                    k   = off % h;
                    b   = (off / h) * 2 * h;
                    x0  = b + k;
                    x1  = b + h + k;
                    x2  = b + h + ((h - k) % h);
                    rom = k << (ab - 1 - s);
                end
            end else begin
                s = ab - 1;
            end
        end
    endfunction

    task automatic chk_cycle(input string dn, input int ab, input int c,
                             input logic busy, input logic done, input logic rv,
                             input logic we, input logic bank,
                             input int x0, input int x1, input int x2, input int rom,
                             input int stg, input int w0, input int w1);
        bit v, wv;
        int e0, e1, e2, er, es, f0, f1, f2, fr, fs, total;
        total = ab * ((1 << ab) / 2 + LAT) + 1;
        model(ab, c, v, e0, e1, e2, er, es);
        model(ab, c - LAT, wv, f0, f1, f2, fr, fs);
        chk({dn, "_busy"}, 32'(busy), 32'(c >= 1 && c <= total));
        chk({dn, "_done"}, 32'(done), 32'(c == total));
        chk({dn, "_rd_valid"}, 32'(rv), 32'(v));
        if (v) begin
            chk({dn, "_x0"}, 32'(x0), 32'(e0));
            chk({dn, "_x1"}, 32'(x1), 32'(e1));
            chk({dn, "_x2"}, 32'(x2), 32'(e2));
            chk({dn, "_rom"}, 32'(rom), 32'(er));
            chk({dn, "_stage"}, 32'(stg), 32'(es));
            chk({dn, "_bank"}, 32'(bank), 32'(es % 2));
        end
        chk({dn, "_we"}, 32'(we), 32'(wv));
        if (wv) begin
            chk({dn, "_wr0"}, 32'(w0), 32'(f0));
            chk({dn, "_wr1"}, 32'(w1), 32'(f1));
        end
    endtask

    task automatic cyc3(input int c);
        chk_cycle("a3", 3, c, if3.oBUSY, if3.oDONE, if3.oRD_VALID, if3.oWE, if3.oBANK,
                  int'(if3.oRD_ADDR_0), int'(if3.oRD_ADDR_1), int'(if3.oRD_ADDR_2),
                  int'(if3.oROM_ADDR), int'(if3.oSTAGE),
                  int'(if3.oWR_ADDR_0), int'(if3.oWR_ADDR_1));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'({if3.oBUSY, if8.oBUSY}), 32'd0);
        chk({tag, "_done"}, 32'({if3.oDONE, if8.oDONE}), 32'd0);
        chk({tag, "_rv_we"}, 32'({if3.oRD_VALID, if3.oWE, if8.oRD_VALID, if8.oWE}), 32'd0);
        chk({tag, "_bank_stage"}, 32'({if3.oBANK, if3.oSTAGE, if8.oBANK, if8.oSTAGE}), 32'd0);
        chk({tag, "_rd3"}, 32'({if3.oRD_ADDR_0, if3.oRD_ADDR_1, if3.oRD_ADDR_2, if3.oROM_ADDR}), 32'd0);
        chk({tag, "_wr3"}, 32'({if3.oWR_ADDR_0, if3.oWR_ADDR_1}), 32'd0);
        chk({tag, "_rd8"}, 32'({if8.oRD_ADDR_0, if8.oRD_ADDR_1, if8.oRD_ADDR_2}), 32'd0);
        chk({tag, "_wr8"}, 32'({if8.oROM_ADDR, if8.oWR_ADDR_0, if8.oWR_ADDR_1}), 32'd0);
    endtask

    // Full A_BIT=3 transform, optionally with an extra iSTART pulse while busy.
    task automatic run3(input bit spurious);
        int sp;
        cap1.delete();
        cap2.delete();
        repeat ($urandom_range(1, 4)) @(negedge clk);
        sp = $urandom_range(2, 20);
        if3.iSTART = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if3.iSTART = spurious && (c == sp);
            cyc3(c);
            if (if3.oRD_VALID) begin
                if (if3.oSTAGE == 2'd1)
                    cap1.push_back({8'(if3.oRD_ADDR_0), 8'(if3.oRD_ADDR_1), 8'(if3.oRD_ADDR_2), 8'(if3.oROM_ADDR)});
                if (if3.oSTAGE == 2'd2)
                    cap2.push_back({8'(if3.oRD_ADDR_0), 8'(if3.oRD_ADDR_1), 8'(if3.oRD_ADDR_2), 8'(if3.oROM_ADDR)});
            end
        end
        if3.iSTART = 1'b0;
    endtask

    initial begin
        int t1[4];
        int t2[4];
        int n, we_cnt, busy_cnt;
        t1 = '{32'h00020200, 32'h01030302, 32'h04060600, 32'h05070702};
        t2 = '{32'h00040400, 32'h01050701, 32'h02060602, 32'h03070503};

        rst_n = 1'b0;
        if3.iSTART = 1'b0;
        if8.iSTART = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        run3(1'b0);
        chk("s1_count", 32'(cap1.size()), 32'd4);
        chk("s2_count", 32'(cap2.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < cap1.size()) chk("s1_issue", 32'(cap1[j]), 32'(t1[j]));
            if (j < cap2.size()) chk("s2_issue", 32'(cap2[j]), 32'(t2[j]));
        end

        run3(1'b1);

        // abort mid stage 1
        repeat (2) @(negedge clk);
        if3.iSTART = 1'b1;
        @(posedge clk);
        n = $urandom_range(8, 14);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if3.iSTART = (c == 3);
            cyc3(c);
        end
        chk("abort_stage", 32'(if3.oSTAGE), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("post_reset_quiet", 32'({if3.oBUSY, if3.oRD_VALID, if3.oWE, if3.oDONE}), 32'd0);
        end

        run3(1'b0);

        // A_BIT=8 full transform
        we_cnt   = 0;
        busy_cnt = 0;
        @(negedge clk);
        if8.iSTART = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 1060; c++) begin
            @(negedge clk);
            if8.iSTART = 1'b0;
            chk_cycle("a8", 8, c, if8.oBUSY, if8.oDONE, if8.oRD_VALID, if8.oWE, if8.oBANK,
                      int'(if8.oRD_ADDR_0), int'(if8.oRD_ADDR_1), int'(if8.oRD_ADDR_2),
                      int'(if8.oROM_ADDR), int'(if8.oSTAGE),
                      int'(if8.oWR_ADDR_0), int'(if8.oWR_ADDR_1));
            if (if8.oWE) we_cnt++;
            if (if8.oBUSY) busy_cnt++;
        end
        chk("a8_we_count", 32'(we_cnt), 32'd1024);
        chk("a8_busy_span", 32'(busy_cnt), 32'd1049);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
